pipe_hazard_ctrl: RTL

Hazard and flush sequencer for the 6-stage core (F1, F2, D, E, M, W). It watches register usage in D and occupancy of E/M, then drives the stall (enable-hold) and clr inputs of the inter-stage pipeline registers. It handles three cases:
- load-use bubbles,
- multi-cycle execute waits,
- branch redirects.

The fetch path uses a two-deep clearable register whose internal stage is not cleared by clr. The redirect flush on the F2→D register is therefore held for two cycles.

---
 rtl/pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and flush sequencer for the six-stage core (F1, F2, D, E, M, W).
// It watches the source registers of the instruction in D and the
// destinations in E/M. It drives the enable-hold (stall_*) and clear
// (flush_*) inputs of the inter-stage pipeline registers for three cases:
// load-use bubbles, multi-cycle execute waits and taken branch redirects.
//
// Parameters
//   RA_W    register address width
//   LD_LAT  cycles by which load data trails the end of E (1..3)
//
// Ports
//   clk                      core clock, all state on the rising edge
//   reset                    asynchronous, active-low; clears all state
//   d_rs1, d_rs2             source registers of the instruction in D
//   d_rs1_use, d_rs2_use     the source is actually read
//   e_rd, m_rd               destination of the instruction in E / M
//   e_wen, m_wen             instruction in E / M writes a register
//   e_load, m_load           instruction in E / M is a load
//   e_redirect               branch/jump in E resolved taken
//   mc_start, mc_done        multi-cycle op in E begins / finishes
//   stall_f/stall_d/stall_e  hold the F1/F2, D and E pipeline registers
//   flush_d/flush_e/flush_m  clear the F2->D, D->E and E->M registers
//   perf_stall_cnt           cycles with stall_d asserted (optional)
//   perf_flush_cnt           redirects taken (optional)
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN
//   Defined:   both performance counters exist and wrap at 2^32.
//   Undefined: both perf ports are tied to zero and no counter flops exist.
//
// Outputs are Mealy. They are a combinational function of the registered
// state and the current inputs, so a hazard is handled in the same cycle
// that it is seen.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter int LD_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] d_rs1,
    input  logic [RA_W-1:0] d_rs2,
    input  logic            d_rs1_use,
    input  logic            d_rs2_use,
    input  logic [RA_W-1:0] e_rd,
    input  logic [RA_W-1:0] m_rd,
    input  logic            e_wen,
    input  logic            m_wen,
    input  logic            e_load,
    input  logic            m_load,
    input  logic            e_redirect,
    input  logic            mc_start,
    input  logic            mc_done,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            flush_d,
    output logic            flush_e,
    output logic            flush_m,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MCWAIT  = 2'd2,
        ST_REDIR   = 2'd3
    } state_t;

    // The cycle that detects a hazard already inserts one bubble. The counter
    // therefore holds the number of extra LDSTALL cycles minus one.
    localparam int BCNT_E_INT = (LD_LAT > 1) ? (LD_LAT - 2) : 0;
    localparam int BCNT_M_INT = (LD_LAT > 2) ? (LD_LAT - 3) : 0;
    localparam logic [1:0] BCNT_E = BCNT_E_INT[1:0];
    localparam logic [1:0] BCNT_M = BCNT_M_INT[1:0];

    state_t     state_reg, state_next;
    logic [1:0] bcnt_reg, bcnt_next;

    // -----------------------------------------------------------------------
    // Hazard detection: compare each D source against the E/M destinations.
    // -----------------------------------------------------------------------
    logic [RA_W-1:0] src_addr [2];
    logic [1:0]      src_use;
    logic [1:0]      hit_e;
    logic [1:0]      hit_m;
    logic            haz_e;
    logic            haz_m;

    assign src_addr[0] = d_rs1;
    assign src_addr[1] = d_rs2;
    assign src_use     = {d_rs2_use, d_rs1_use};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign hit_e[gi] = src_use[gi] && (src_addr[gi] == e_rd);
            assign hit_m[gi] = src_use[gi] && (src_addr[gi] == m_rd);
        end
    endgenerate

    // x0 is hardwired to zero, so writing it never creates a dependency.
    assign haz_e = e_wen && (e_rd != '0) && (|hit_e);
    assign haz_m = m_wen && (m_rd != '0) && (|hit_m);

    // -----------------------------------------------------------------------
    // Next-state and Mealy output logic.
    // -----------------------------------------------------------------------
    logic raw_stall_f, raw_stall_d, raw_stall_e;
    logic raw_flush_d, raw_flush_e, raw_flush_m;

    always_comb begin
        state_next  = state_reg;
        bcnt_next   = bcnt_reg;
        raw_stall_f = 1'b0;
        raw_stall_d = 1'b0;
        raw_stall_e = 1'b0;
        raw_flush_d = 1'b0;
        raw_flush_e = 1'b0;
        raw_flush_m = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (e_redirect) begin
                    raw_flush_d = 1'b1;
                    raw_flush_e = 1'b1;
                    state_next  = ST_REDIR;
                end else if (mc_start && !mc_done) begin
                    raw_stall_f = 1'b1;
                    raw_stall_d = 1'b1;
                    raw_stall_e = 1'b1;
                    raw_flush_m = 1'b1;
                    state_next  = ST_MCWAIT;
                end else if (e_load && haz_e) begin
                    raw_stall_f = 1'b1;
                    raw_stall_d = 1'b1;
                    raw_flush_e = 1'b1;
                    if (LD_LAT > 1) begin
                        bcnt_next  = BCNT_E;
                        state_next = ST_LDSTALL;
                    end
                end else if (m_load && haz_m && (LD_LAT > 1)) begin
                    // The load is one slot further ahead, so one fewer bubble is needed.
                    raw_stall_f = 1'b1;
                    raw_stall_d = 1'b1;
                    raw_flush_e = 1'b1;
                    if (LD_LAT > 2) begin
                        bcnt_next  = BCNT_M;
                        state_next = ST_LDSTALL;
                    end
                end
            end

            ST_LDSTALL: begin
                // E holds a bubble, so any redirect seen here is spurious.
                raw_stall_f = 1'b1;
                raw_stall_d = 1'b1;
                raw_flush_e = 1'b1;
                if (bcnt_reg == 2'd0) begin
                    state_next = ST_RUN;
                end else begin
                    bcnt_next = bcnt_reg - 2'd1;
                end
            end

            ST_MCWAIT: begin
                if (mc_done) begin
                    state_next = ST_RUN;
                end else begin
                    raw_stall_f = 1'b1;
                    raw_stall_d = 1'b1;
                    raw_stall_e = 1'b1;
                    raw_flush_m = 1'b1;
                end
            end

            ST_REDIR: begin
                // The fetch internal stage is not cleared by clr, so the
                // wrong-path word reaches F2->D one cycle later.
                raw_flush_d = 1'b1;
                state_next  = ST_RUN;
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Gate the outputs with reset so that they drop at once even in RUN,
    // where they depend only on the inputs.
    assign stall_f = reset & raw_stall_f;
    assign stall_d = reset & raw_stall_d;
    assign stall_e = reset & raw_stall_e;
    assign flush_d = reset & raw_flush_d;
    assign flush_e = reset & raw_flush_e;
    assign flush_m = reset & raw_flush_m;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            bcnt_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            bcnt_reg  <= bcnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Optional performance counters.
    // -----------------------------------------------------------------------
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else begin
            if (raw_stall_d) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if ((state_reg == ST_RUN) && e_redirect) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
    assign perf_flush_cnt = flush_cnt_reg;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
